// File: rtl/pin_toggle_monitor_pkg.sv
// pin_toggle_monitor_pkg: shared state encoding, default parameters and helpers
package pin_toggle_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAIL    = 2'd3
    } state_t;

    localparam int unsigned DEF_EXP_HALF = 5000001;
    localparam int unsigned DEF_TOL      = 16;
    localparam int unsigned DEF_TIMEOUT  = 10000002;
    localparam int unsigned DEF_GOOD_REQ = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pin_edge_sync.sv
// pin_edge_sync: two-flop synchronizer plus history flop, registered any-edge pulse
module pin_edge_sync (
    input  logic fpga_clk,
    input  logic fpga_rstn,
    input  logic pin_in,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    // Synchronize the pin, keep one sample of history and flag any change
    always_ff @(posedge fpga_clk or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            hist       <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= pin_in;
            sync2      <= sync1;
            hist       <= sync2;
            edge_pulse <= sync2 ^ hist;
        end
    end

endmodule

// File: rtl/pin_toggle_monitor.sv
// pin_toggle_monitor: measures pin edge-to-edge intervals, locks on a good rate, flags drift or a stuck pin
module pin_toggle_monitor
    import pin_toggle_monitor_pkg::*;
#(
    parameter int unsigned EXP_HALF = DEF_EXP_HALF,
    parameter int unsigned TOL      = DEF_TOL,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned GOOD_REQ = DEF_GOOD_REQ
) (
    input  logic        fpga_clk,
    input  logic        fpga_rstn,
    input  logic        pin_in,
    input  logic        clr,
    output logic        period_valid,
    output logic [31:0] last_period,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic        status_ok,
    output logic        status_fail,
    output logic        stuck
);

    localparam logic [31:0] WIN_LO   = 32'(EXP_HALF - TOL);
    localparam logic [31:0] WIN_HI   = 32'(EXP_HALF + TOL);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [15:0] GOOD_LIM = 16'(GOOD_REQ);

    state_t      state;
    state_t      state_nxt;
    logic        edge_pulse;
    logic [31:0] period_cnt;
    logic [31:0] measured;
    logic [15:0] consec_good;
    logic [15:0] consec_nxt;
    logic [15:0] consec_inc;
    logic        in_win;
    logic        timeout_hit;
    logic        measure_now;
    logic        stuck_set;

    pin_edge_sync u_sync (
        .fpga_clk  (fpga_clk),
        .fpga_rstn (fpga_rstn),
        .pin_in    (pin_in),
        .edge_pulse(edge_pulse)
    );

    // The counter is about to reach TIMEOUT this cycle; a coincident edge takes priority
    assign measured    = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + 32'd1;
    assign in_win      = (measured >= WIN_LO) && (measured <= WIN_HI);
    assign timeout_hit = !edge_pulse && (period_cnt == TO_LAST);
    assign measure_now = edge_pulse && (state != ST_IDLE);
    assign consec_inc  = consec_good + 16'd1;
    assign stuck_set   = timeout_hit && (state != ST_FAIL);

    // Next-state and consecutive-good tracking
    always_comb begin
        state_nxt  = state;
        consec_nxt = consec_good;
        unique case (state)
            ST_IDLE:    state_nxt = edge_pulse ? ST_MEASURE : (timeout_hit ? ST_FAIL : ST_IDLE);
            ST_MEASURE: begin
                consec_nxt = edge_pulse ? (in_win ? consec_inc : 16'd0) : consec_good;
                state_nxt  = (edge_pulse && in_win && consec_inc >= GOOD_LIM) ? ST_LOCKED :
                             (timeout_hit ? ST_FAIL : ST_MEASURE);
            end
            ST_LOCKED:  state_nxt = ((edge_pulse && !in_win) || timeout_hit) ? ST_FAIL : ST_LOCKED;
            default:    state_nxt = ST_FAIL;
        endcase
        if (clr) state_nxt = ST_IDLE;
    end

    // State register with status flags decoded from the next state
    always_ff @(posedge fpga_clk or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            state       <= ST_IDLE;
            status_ok   <= 1'b0;
            status_fail <= 1'b0;
        end else begin
            state       <= state_nxt;
            status_ok   <= (state_nxt == ST_LOCKED);
            status_fail <= (state_nxt == ST_FAIL);
        end
    end

    // Interval counter, measurement capture and saturating tallies
    always_ff @(posedge fpga_clk or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            period_cnt   <= '0;
            period_valid <= 1'b0;
            last_period  <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            consec_good  <= '0;
            stuck        <= 1'b0;
        end else if (clr) begin
            period_cnt   <= '0;
            period_valid <= 1'b0;
            last_period  <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            consec_good  <= '0;
            stuck        <= 1'b0;
        end else begin
            period_cnt   <= edge_pulse ? '0 : measured;
            period_valid <= measure_now;
            consec_good  <= consec_nxt;
            stuck        <= stuck | stuck_set;
            if (measure_now) begin
                last_period <= measured;
                good_cnt    <= in_win ? sat_inc16(good_cnt) : good_cnt;
                bad_cnt     <= in_win ? bad_cnt : sat_inc16(bad_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pin_toggle_monitor.sv
// tb_pin_toggle_monitor: directed and randomized interval stimulus against an event-level model
module tb_pin_toggle_monitor;

    localparam int EXP_HALF = 20;
    localparam int TOL      = 2;
    localparam int TIMEOUT  = 40;
    localparam int GOOD_REQ = 3;
    localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2, M_FAIL = 3;

    logic        fpga_clk = 1'b0;
    logic        fpga_rstn = 1'b0;
    logic        pin_in = 1'b0;
    logic        clr = 1'b0;
    logic        period_valid;
    logic [31:0] last_period;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
    logic        status_ok;
    logic        status_fail;
    logic        stuck;

    int n_cmp = 0;
    int n_bad = 0;
    int m_st, m_last, m_good, m_bad, m_consec, since;
    bit m_stuck, m_valid;

    always #5 fpga_clk = ~fpga_clk;

    pin_toggle_monitor #(
        .EXP_HALF(EXP_HALF),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT),
        .GOOD_REQ(GOOD_REQ)
    ) dut (
        .fpga_clk    (fpga_clk),
        .fpga_rstn   (fpga_rstn),
        .pin_in      (pin_in),
        .clr         (clr),
        .period_valid(period_valid),
        .last_period (last_period),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt),
        .status_ok   (status_ok),
        .status_fail (status_fail),
        .stuck       (stuck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic m_clear();
        m_st = M_IDLE; m_last = 0; m_good = 0; m_bad = 0; m_consec = 0;
        m_stuck = 0; m_valid = 0;
    endtask

    // One pin transition whose preceding interval was n cycles
    task automatic m_edge(input int n);
        bit win;
        m_valid = 0;
        if ((m_st == M_MEAS || m_st == M_LOCK) && n > TIMEOUT) begin
            m_st = M_FAIL;
            m_stuck = 1;
        end
        if (m_st == M_IDLE) begin
            m_st = M_MEAS;
            return;
        end
        win = (n >= EXP_HALF - TOL) && (n <= EXP_HALF + TOL);
        m_valid = 1;
        m_last = n;
        if (win) m_good = (m_good < 65535) ? m_good + 1 : m_good;
        else     m_bad  = (m_bad  < 65535) ? m_bad  + 1 : m_bad;
        if (m_st == M_MEAS) begin
            m_consec = win ? m_consec + 1 : 0;
            if (m_consec >= GOOD_REQ) m_st = M_LOCK;
        end else if (m_st == M_LOCK && !win) begin
            m_st = M_FAIL;
        end
    endtask

    task automatic check_outs(input string w);
        chk({w, "/period_valid"}, 32'(period_valid), 32'(m_valid));
        chk({w, "/last_period"}, last_period, 32'(m_last));
        chk({w, "/good_cnt"}, 32'(good_cnt), 32'(m_good));
        chk({w, "/bad_cnt"}, 32'(bad_cnt), 32'(m_bad));
        chk({w, "/status_ok"}, 32'(status_ok), 32'(m_st == M_LOCK));
        chk({w, "/status_fail"}, 32'(status_fail), 32'(m_st == M_FAIL));
        chk({w, "/stuck"}, 32'(stuck), 32'(m_stuck));
    endtask

    // Toggle the pin now, check the result once it has propagated, next toggle after gap cycles
    task automatic flip_chk(input int gap);
        pin_in = ~pin_in;
        m_edge(since);
        repeat (4) tick();
        check_outs("flip");
        tick();
        chk("pv_drop", 32'(period_valid), 32'd0);
        repeat (gap - 5) tick();
        since = gap;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_clear();
        check_outs("clr");
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 9);
        return (r < 7) ? $urandom_range(EXP_HALF - TOL, EXP_HALF + TOL) :
               (r == 7) ? EXP_HALF - TOL - 1 :
               (r == 8) ? EXP_HALF + TOL + 1 : $urandom_range(24, TIMEOUT + 1);
    endfunction

    initial begin
        int gaps_a[9] = '{20, 20, 20, 20, 18, 22, 25, 20, 20};
        int gaps_b[8] = '{22, 17, 20, 23, 20, 20, 20, 20};
        m_clear();
        since = 0;
        #12;
        check_outs("reset");
        @(posedge fpga_clk);
        #1;
        fpga_rstn = 1'b1;
        repeat (TIMEOUT - 1) tick();
        chk("idle_pre_timeout/stuck", 32'(stuck), 32'd0);
        chk("idle_pre_timeout/status_fail", 32'(status_fail), 32'd0);
        tick();
        m_st = M_FAIL;
        m_stuck = 1;
        check_outs("idle_timeout");
        clr_pulse();
        // lock, bounds while locked, drift to FAIL, counting continues in FAIL
        foreach (gaps_a[i]) flip_chk(gaps_a[i]);
        // clr lands on the same cycle as an edge while in FAIL
        pin_in = ~pin_in;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_clear();
        check_outs("clr_edge");
        repeat (5) tick();
        flip_chk(20);
        // window bounds while measuring, then lock and hold the pin
        foreach (gaps_b[i]) flip_chk(gaps_b[i]);
        pin_in = ~pin_in;
        m_edge(since);
        repeat (4) tick();
        check_outs("hold_edge");
        repeat (TIMEOUT - 1) tick();
        chk("hold_pre_timeout/stuck", 32'(stuck), 32'd0);
        chk("hold_pre_timeout/status_ok", 32'(status_ok), 32'd1);
        tick();
        m_st = M_FAIL;
        m_stuck = 1;
        m_valid = 0;
        check_outs("hold_timeout");
        since = TIMEOUT + 4;
        flip_chk(20);
        // asynchronous reset in the middle of a locked interval
        clr_pulse();
        repeat (4) flip_chk(20);
        repeat (3) tick();
        #2;
        fpga_rstn = 1'b0;
        pin_in = 1'b0;
        m_clear();
        #1;
        check_outs("async_reset");
        tick();
        tick();
        fpga_rstn = 1'b1;
        repeat (4) flip_chk(20);
        // randomized intervals around the window and up to the timeout
        repeat (4) begin
            clr_pulse();
            repeat (12) flip_chk(rand_gap());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pin_toggle_monitor.md
PIN_TOGGLE_MONITOR -- requirements
Module: pin_toggle_monitor

Interface
REQ-001 Parameter EXP_HALF, default 5000001, expected clock cycles between consecutive pin edges.
REQ-002 Parameter TOL, default 16, allowed +/- deviation, in cycles, from EXP_HALF.
REQ-003 Parameter TIMEOUT, default 10000002, edge-free cycle count that declares the pin stuck.
REQ-004 Parameter GOOD_REQ, default 4, consecutive in-window intervals required to lock.
REQ-005 fpga_clk  in  1  single clock for all logic.
REQ-006 fpga_rstn  in  1  reset, asynchronous, active-low.
REQ-007 pin_in  in  1  monitored toggle pin, asynchronous to fpga_clk.
REQ-008 clr  in  1  synchronous clear, one-cycle pulse.
REQ-009 period_valid  out  1  one-cycle pulse when last_period updates.
REQ-010 last_period  out  32  most recent measured edge-to-edge interval, in cycles.
REQ-011 good_cnt  out  16  count of in-window intervals, saturating.
REQ-012 bad_cnt  out  16  count of out-of-window intervals, saturating.
REQ-013 status_ok  out  1  high while in LOCKED.
REQ-014 status_fail  out  1  high while in FAIL; sticky.
REQ-015 stuck  out  1  FAIL was entered by timeout; sticky.

Function
REQ-016 pin_in SHALL pass through a 2-flop synchronizer and then a third history flop; edge = sync2 XOR hist, covering both rising and falling edges.
REQ-017 The edge pulse SHALL assert exactly 3 cycles after pin_in changes, given the change is stable across the sampling edge.
REQ-018 period_cnt (32 bit) SHALL clear to 0 on an edge cycle and otherwise increment, saturating at 32'hFFFFFFFF.
REQ-019 On a measured edge, measured interval = period_cnt+1: a pin toggling every N cycles yields N.
REQ-020 In-window SHALL mean EXP_HALF-TOL <= measured <= EXP_HALF+TOL, inclusive at both bounds.
REQ-021 States: IDLE, MEASURE, LOCKED, FAIL.
REQ-022 In IDLE, the first edge SHALL only restart period_cnt and enter MEASURE: no measurement, no period_valid.
REQ-023 In MEASURE and LOCKED, every edge SHALL load last_period, pulse period_valid and increment good_cnt or bad_cnt.
REQ-024 In MEASURE, an in-window edge SHALL increment consec_good; when consec_good reaches GOOD_REQ, go to LOCKED.
REQ-025 In MEASURE, an out-of-window edge SHALL clear consec_good and remain in MEASURE.
REQ-026 In LOCKED, an out-of-window edge SHALL go to FAIL with stuck=0.
REQ-027 In IDLE, MEASURE or LOCKED, period_cnt reaching TIMEOUT with no edge SHALL go to FAIL and set stuck=1.
REQ-028 In FAIL, edges SHALL still be measured and counted, but no state change occurs until clr.
REQ-029 An edge in the same cycle that TIMEOUT is reached SHALL count as an edge; the timeout is ignored.
REQ-030 good_cnt and bad_cnt SHALL hold at 16'hFFFF without wrapping.
REQ-031 clr SHALL return to IDLE and zero all counters, last_period, consec_good, stuck and period_cnt; clr wins over a coincident edge.
REQ-032 status_ok and status_fail SHALL be registered state decodes, never both high.

Reset
REQ-033 While fpga_rstn is low, all flops SHALL clear: state=IDLE, every output 0, synchronizer and history flops 0.
REQ-034 Reset asserted mid-measurement SHALL discard the partial interval; after release the first edge is treated per REQ-022.

Structure
REQ-035 A shared package SHALL hold the state encoding (2 bit) and default parameter constants.
REQ-036 The synchronizer plus edge detector SHALL be sub-module pin_edge_sync (in pin_in, out edge); everything else is flat.

Verification (sim parameters: EXP_HALF=20, TOL=2, TIMEOUT=40, GOOD_REQ=3)
REQ-037 pin_in toggles every 20 cycles -> period_valid on the 2nd and later edges with last_period=20; status_ok=1 after the 4th edge; good_cnt=3.
REQ-038 Intervals 18 then 22 (bounds) -> both counted good; interval 17 or 23 -> bad_cnt+1 and consec_good=0.
REQ-039 Locked pin, then one interval of 25 -> status_fail=1, stuck=0, status_ok=0; later good intervals still increment good_cnt while FAIL holds.
REQ-040 Locked pin, then pin_in held constant -> FAIL and stuck=1 exactly when period_cnt hits 40; held pin from reset -> same.
REQ-041 clr coincident with an edge while in FAIL -> next cycle IDLE, all outputs 0; the following edge produces no period_valid.
REQ-042 fpga_rstn pulsed low mid-interval in LOCKED -> outputs 0 immediately (asynchronous); relock requires 1 edge plus GOOD_REQ good intervals.
